// File: rtl/mprj2_pwrgood_pkg.sv
// mprj2_pwrgood_pkg: shared state encoding, counter width and counter helper for the mprj2 power-good sequencer
package mprj2_pwrgood_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        OFF     = 2'b00,
        QUALIFY = 2'b01,
        UNISO   = 2'b10,
        RUN     = 2'b11
    } pg_state_t;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/mprj2_hi_sync.sv
// mprj2_hi_sync: STAGES-deep flop chain bringing an asynchronous power-indicator net into the clock domain
//   clock  : destination clock
//   resetb : asynchronous active-low clear of every stage
//   d      : asynchronous input
//   q      : synchronized output (last stage)
module mprj2_hi_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clock or negedge resetb)
        if (!resetb) sr <= '0;
        else         sr <= {sr[STAGES-2:0], d};

    assign q = sr[STAGES-1];

endmodule

// File: rtl/mprj2_pwrgood_seq.sv
// mprj2_pwrgood_seq: qualifies the user-area-2 HI net and sequences isolation release and user reset
//   clock         : management clock
//   resetb        : asynchronous active-low reset
//   mprj2_hi      : asynchronous HI net from the user-area-2 tie-high cell
//   mprj2_en      : software enable, synchronous to clock
//   mprj2_iso_n   : 1 = interface pass-through, 0 = isolated
//   mprj2_rst_n   : active-low reset to user area 2
//   mprj2_pwrgood : power qualified stable
//   mprj2_state   : FSM state for status readback
//   mprj2_irq / mprj2_irq_clr : sticky power-lost flag and its clear, present only with MPRJ2_PWRGOOD_IRQ_EN
module mprj2_pwrgood_seq
    import mprj2_pwrgood_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 256,
    parameter int RST_DELAY     = 16
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       mprj2_hi,
    input  logic       mprj2_en,
    output logic       mprj2_iso_n,
    output logic       mprj2_rst_n,
    output logic       mprj2_pwrgood,
`ifdef MPRJ2_PWRGOOD_IRQ_EN
    output logic       mprj2_irq,
    input  logic       mprj2_irq_clr,
`endif
    output logic [1:0] mprj2_state
);

    localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(RST_DELAY - 1);

    pg_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             shutting;
    logic             hi_s;

    mprj2_hi_sync #(.STAGES(SYNC_STAGES)) u_hi_sync (
        .clock  (clock),
        .resetb (resetb),
        .d      (mprj2_hi),
        .q      (hi_s)
    );

    // Once pwrgood is set it stays set until power loss, so a drained FSM
    // sitting in QUALIFY can re-enter UNISO without requalifying.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state         <= OFF;
            cnt           <= '0;
            shutting      <= 1'b0;
            mprj2_iso_n   <= 1'b0;
            mprj2_rst_n   <= 1'b0;
            mprj2_pwrgood <= 1'b0;
        end else if (!hi_s) begin
            state         <= OFF;
            cnt           <= '0;
            shutting      <= 1'b0;
            mprj2_iso_n   <= 1'b0;
            mprj2_rst_n   <= 1'b0;
            mprj2_pwrgood <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    state <= QUALIFY;
                    cnt   <= '0;
                end
                QUALIFY: begin
                    if (mprj2_pwrgood || cnt == QUAL_LAST) begin
                        mprj2_pwrgood <= 1'b1;
                        if (mprj2_en) begin
                            state       <= UNISO;
                            cnt         <= '0;
                            shutting    <= 1'b0;
                            mprj2_iso_n <= 1'b1;
                        end else begin
                            cnt <= cnt_inc(cnt);
                        end
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end
                UNISO: begin
                    if (shutting) begin
                        // Drain ignores the enable; a re-enable is honoured from QUALIFY.
                        if (cnt == DLY_LAST) begin
                            state       <= QUALIFY;
                            cnt         <= '0;
                            shutting    <= 1'b0;
                            mprj2_iso_n <= 1'b0;
                        end else begin
                            cnt <= cnt_inc(cnt);
                        end
                    end else if (!mprj2_en) begin
                        shutting <= 1'b1;
                        cnt      <= '0;
                    end else if (cnt == DLY_LAST) begin
                        state       <= RUN;
                        cnt         <= '0;
                        mprj2_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end
                RUN: begin
                    if (!mprj2_en) begin
                        state       <= UNISO;
                        cnt         <= '0;
                        shutting    <= 1'b1;
                        mprj2_rst_n <= 1'b0;
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end
                default: begin
                    state <= OFF;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign mprj2_state = state;

`ifdef MPRJ2_PWRGOOD_IRQ_EN
    // pwrgood only ever falls on power loss, so the set term coincides with that edge.
    always_ff @(posedge clock or negedge resetb)
        if (!resetb) mprj2_irq <= 1'b0;
        else         mprj2_irq <= (mprj2_pwrgood & ~hi_s) | (mprj2_irq & ~mprj2_irq_clr);
`else
`endif

endmodule

// File: tb/tb_mprj2_pwrgood_seq.sv
// tb_mprj2_pwrgood_seq: directed and randomized checks of the power-good sequencer against a countdown-based model
module tb_mprj2_pwrgood_seq;

    localparam int SYNC = 2, STABLE = 8, DLY = 4;

    logic       clock = 1'b0, resetb = 1'b1, mprj2_hi = 1'b0, mprj2_en = 1'b0;
    logic       mprj2_iso_n, mprj2_rst_n, mprj2_pwrgood;
    logic [1:0] mprj2_state;
`ifdef MPRJ2_PWRGOOD_IRQ_EN
    logic       mprj2_irq, mprj2_irq_clr = 1'b0;
`endif

    always #5 clock = ~clock;

    mprj2_pwrgood_seq #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .RST_DELAY(DLY)) dut (
        .clock         (clock),
        .resetb        (resetb),
        .mprj2_hi      (mprj2_hi),
        .mprj2_en      (mprj2_en),
        .mprj2_iso_n   (mprj2_iso_n),
        .mprj2_rst_n   (mprj2_rst_n),
        .mprj2_pwrgood (mprj2_pwrgood),
`ifdef MPRJ2_PWRGOOD_IRQ_EN
        .mprj2_irq     (mprj2_irq),
        .mprj2_irq_clr (mprj2_irq_clr),
`endif
        .mprj2_state   (mprj2_state)
    );

    int n_tests = 0, n_fail = 0, cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: phase number plus countdown of edges left in the current wait.
    int m_st, m_left;
    bit m_pg, m_iso, m_rst, m_drain, m_irq;
    bit hq[$];

    task automatic model_reset();
        m_st = 0; m_left = 0; m_pg = 0; m_iso = 0; m_rst = 0; m_drain = 0; m_irq = 0;
        hq = {};
        repeat (SYNC) hq.push_back(1'b0);
    endtask

    task automatic model_step(input bit hi, input bit en, input bit clr);
        bit hs;
        hs = hq.pop_front();
        hq.push_back(hi);
        m_irq = (m_pg && !hs) || (m_irq && !clr);
        if (!hs) begin
            m_st = 0; m_pg = 0; m_iso = 0; m_rst = 0; m_drain = 0;
        end else if (m_st == 0) begin
            m_st = 1; m_left = STABLE - 1;
        end else if (m_st == 1) begin
            if (m_pg || m_left == 0) begin
                m_pg = 1;
                if (en) begin m_st = 2; m_iso = 1; m_drain = 0; m_left = DLY - 1; end
            end else m_left--;
        end else if (m_st == 2) begin
            if (m_drain) begin
                if (m_left == 0) begin m_st = 1; m_iso = 0; m_drain = 0; end
                else m_left--;
            end else if (!en) begin
                m_drain = 1; m_left = DLY - 1;
            end else if (m_left == 0) begin
                m_st = 3; m_rst = 1;
            end else m_left--;
        end else if (!en) begin
            m_st = 2; m_rst = 0; m_drain = 1; m_left = DLY - 1;
        end
    endtask

    task automatic tick();
        bit clr;
        clr = 1'b0;
`ifdef MPRJ2_PWRGOOD_IRQ_EN
        clr = mprj2_irq_clr;
`endif
        @(posedge clock);
        model_step(mprj2_hi, mprj2_en, clr);
        cyc++;
        #1;
        check("state", 32'(mprj2_state), 32'(m_st));
        check("pwrgood", 32'(mprj2_pwrgood), 32'(m_pg));
        check("iso_n", 32'(mprj2_iso_n), 32'(m_iso));
        check("rst_n", 32'(mprj2_rst_n), 32'(m_rst));
`ifdef MPRJ2_PWRGOOD_IRQ_EN
        check("irq", 32'(mprj2_irq), 32'(m_irq));
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(mprj2_state), 0);
        check({tag, "_pg"}, 32'(mprj2_pwrgood), 0);
        check({tag, "_iso"}, 32'(mprj2_iso_n), 0);
        check({tag, "_rst"}, 32'(mprj2_rst_n), 0);
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        #1;
        check_reset_vals("reset");
        model_reset();
        #2;
        resetb = 1'b1;
        cyc = 0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Bring-up with enable held
        mprj2_hi = 1; mprj2_en = 1;
        repeat (10) tick();
        check("bringup_pg_c10", 32'(mprj2_pwrgood), 0);
        tick();
        check("bringup_pg_c11", 32'(mprj2_pwrgood), 1);
        check("bringup_iso_c11", 32'(mprj2_iso_n), 1);
        check("bringup_rst_c11", 32'(mprj2_rst_n), 0);
        repeat (3) tick();
        check("bringup_rst_c14", 32'(mprj2_rst_n), 0);
        tick();
        check("bringup_rst_c15", 32'(mprj2_rst_n), 1);
        check("bringup_st_c15", 32'(mprj2_state), 3);

        // Orderly shutdown then re-enable
        mprj2_en = 0;
        tick();
        check("shut_rst", 32'(mprj2_rst_n), 0);
        check("shut_iso_held", 32'(mprj2_iso_n), 1);
        repeat (3) tick();
        check("shut_iso_c3", 32'(mprj2_iso_n), 1);
        tick();
        check("shut_iso_c4", 32'(mprj2_iso_n), 0);
        check("shut_st", 32'(mprj2_state), 1);
        check("shut_pg", 32'(mprj2_pwrgood), 1);
        mprj2_en = 1;
        tick();
        check("reen_st_uniso", 32'(mprj2_state), 2);
        repeat (3) tick();
        check("reen_st_c3", 32'(mprj2_state), 2);
        tick();
        check("reen_st_run", 32'(mprj2_state), 3);

        // Power loss from RUN
        mprj2_hi = 0;
        repeat (3) tick();
        check_reset_vals("ploss");
`ifdef MPRJ2_PWRGOOD_IRQ_EN
        check("irq_set", 32'(mprj2_irq), 1);
        repeat (3) tick();
        check("irq_sticky", 32'(mprj2_irq), 1);
        mprj2_irq_clr = 1;
        tick();
        check("irq_cleared", 32'(mprj2_irq), 0);
        mprj2_irq_clr = 0;
`endif
        // Requalify without enable, then lose power with clear coinciding with the fall
        mprj2_hi = 1; mprj2_en = 0;
        repeat (14) tick();
        check("requal_pg", 32'(mprj2_pwrgood), 1);
        mprj2_hi = 0;
        repeat (2) tick();
`ifdef MPRJ2_PWRGOOD_IRQ_EN
        mprj2_irq_clr = 1;
`endif
        tick();
        check("fall_pg", 32'(mprj2_pwrgood), 0);
`ifdef MPRJ2_PWRGOOD_IRQ_EN
        check("irq_set_wins", 32'(mprj2_irq), 1);
        mprj2_irq_clr = 0;
`endif

        // Short HI pulses never qualify
        do_reset();
        mprj2_en = 1;
        repeat (4) begin
            for (int i = 0; i < 10; i++) begin
                mprj2_hi = (i < 5);
                tick();
                check("pulse_st_le1", 32'(mprj2_state <= 2'd1), 1);
            end
        end

        // Qualify with enable low, then enable
        do_reset();
        mprj2_hi = 1; mprj2_en = 0;
        repeat (11) tick();
        check("noen_pg", 32'(mprj2_pwrgood), 1);
        check("noen_iso", 32'(mprj2_iso_n), 0);
        check("noen_st", 32'(mprj2_state), 1);
        repeat (5) tick();
        check("noen_st_hold", 32'(mprj2_state), 1);
        mprj2_en = 1;
        tick();
        check("en_st_uniso", 32'(mprj2_state), 2);
        repeat (3) tick();
        check("en_st_c3", 32'(mprj2_state), 2);
        tick();
        check("en_st_run", 32'(mprj2_state), 3);

        // Async reset mid-UNISO and full requalification
        do_reset();
        mprj2_hi = 1; mprj2_en = 1;
        repeat (12) tick();
        check("mid_st_uniso", 32'(mprj2_state), 2);
        resetb = 0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        #2;
        resetb = 1;
        cyc = 0;
        repeat (10) tick();
        check("midrst_pg_c10", 32'(mprj2_pwrgood), 0);
        tick();
        check("midrst_pg_c11", 32'(mprj2_pwrgood), 1);

        // Randomized traffic against the model
        do_reset();
        mprj2_hi = 1; mprj2_en = 1;
        repeat (3000) begin
            mprj2_hi = mprj2_hi ? ($urandom_range(0, 79) != 0) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) mprj2_en = ~mprj2_en;
`ifdef MPRJ2_PWRGOOD_IRQ_EN
            mprj2_irq_clr = ($urandom_range(0, 7) == 0);
`endif
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
